// File: rtl/time_setter_if.sv
// Key, live-time and set-bus signals between the keypad side and time_setter.
// master drives keys and live time; slave is the time_setter itself.
interface time_setter_if;
    logic        key_mode;
    logic        key_next;
    logic        key_up;
    logic        key_down;

    logic [11:0] cur_year;
    logic [3:0]  cur_mon;
    logic [2:0]  cur_week;
    logic [4:0]  cur_day;
    logic [4:0]  cur_hour;
    logic [5:0]  cur_min;
    logic [5:0]  cur_sec;

    logic [11:0] year_set;
    logic [3:0]  mon_set;
    logic [2:0]  week_set;
    logic [4:0]  day_set;
    logic [4:0]  hour_set;
    logic [5:0]  min_set;
    logic [5:0]  sec_set;
    logic        time_set;
    logic        editing;
    logic [2:0]  field;

    modport master (
        output key_mode, key_next, key_up, key_down,
        output cur_year, cur_mon, cur_week, cur_day,
        output cur_hour, cur_min, cur_sec,
        input  year_set, mon_set, week_set, day_set,
        input  hour_set, min_set, sec_set,
        input  time_set, editing, field
    );

    modport slave (
        input  key_mode, key_next, key_up, key_down,
        input  cur_year, cur_mon, cur_week, cur_day,
        input  cur_hour, cur_min, cur_sec,
        output year_set, mon_set, week_set, day_set,
        output hour_set, min_set, sec_set,
        output time_set, editing, field
    );
endinterface

// File: rtl/time_setter.sv
// Keypad-driven calendar time editor: loads live time, edits fields with
// wrap and month-length clamping, then strobes the result to the calendar.
module time_setter #(
    parameter int YEAR_MIN = 1900,
    parameter int YEAR_MAX = 2199
) (
    input  logic         clk,
    input  logic         rst_n,
    time_setter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;

    localparam logic [11:0] YMIN = 12'(YEAR_MIN);
    localparam logic [11:0] YMAX = 12'(YEAR_MAX);

    function automatic logic is_leap(input logic [11:0] y);
        return ((y % 12'd4 == 12'd0) && (y % 12'd100 != 12'd0))
            || (y % 12'd400 == 12'd0);
    endfunction

    function automatic logic [4:0] dim(input logic [11:0] y,
                                       input logic [3:0]  m);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    function automatic logic [11:0] step(input logic [11:0] v,
                                         input logic [11:0] lo,
                                         input logic [11:0] hi,
                                         input logic        up);
        if (up) return (v >= hi) ? lo : v + 12'd1;
        return (v <= lo) ? hi : v - 12'd1;
    endfunction

    state_t      state_q;
    logic [11:0] year_q, year_d, ld_year;
    logic [3:0]  mon_q, mon_d, ld_mon;
    logic [2:0]  week_q, week_d, ld_week;
    logic [4:0]  day_q, day_d, ld_day;
    logic [4:0]  hour_q, hour_d, ld_hour;
    logic [5:0]  min_q, min_d, ld_min;
    logic [5:0]  sec_q, sec_d, ld_sec;
    logic [2:0]  field_q, field_d;
    logic        time_set_q;
    logic        editing_q;
    logic [4:0]  dim_q;
    logic [4:0]  dim_d;
    logic        up;

    assign dim_q = dim(year_q, mon_q);
    assign up    = bus.key_up;

    // Out-of-range live values fall back to the field minimum
    always_comb begin
        ld_year = (bus.cur_year < YMIN || bus.cur_year > YMAX)
                ? YMIN : bus.cur_year;
        ld_mon  = (bus.cur_mon == 4'd0 || bus.cur_mon > 4'd12)
                ? 4'd1 : bus.cur_mon;
        ld_day  = (bus.cur_day == 5'd0 || bus.cur_day > dim(ld_year, ld_mon))
                ? 5'd1 : bus.cur_day;
        ld_week = (bus.cur_week == 3'd0) ? 3'd1 : bus.cur_week;
        ld_hour = (bus.cur_hour > 5'd23) ? 5'd0 : bus.cur_hour;
        ld_min  = (bus.cur_min > 6'd59) ? 6'd0 : bus.cur_min;
        ld_sec  = (bus.cur_sec > 6'd59) ? 6'd0 : bus.cur_sec;
    end

    // Edit step; key_mode precedence is resolved in the state machine
    always_comb begin
        year_d  = year_q;
        mon_d   = mon_q;
        week_d  = week_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        field_d = field_q;
        if (bus.key_next) begin
            field_d = (field_q == 3'd6) ? 3'd0 : field_q + 3'd1;
        end else if (bus.key_up || bus.key_down) begin
            case (field_q)
                3'd0: year_d = step(year_q, YMIN, YMAX, up);
                3'd1: mon_d  = 4'(step({8'd0, mon_q}, 12'd1, 12'd12, up));
                3'd2: day_d  = 5'(step({7'd0, day_q}, 12'd1,
                                       {7'd0, dim_q}, up));
                3'd3: week_d = 3'(step({9'd0, week_q}, 12'd1, 12'd7, up));
                3'd4: hour_d = 5'(step({7'd0, hour_q}, 12'd0, 12'd23, up));
                3'd5: min_d  = 6'(step({6'd0, min_q}, 12'd0, 12'd59, up));
                3'd6: sec_d  = 6'(step({6'd0, sec_q}, 12'd0, 12'd59, up));
                default: ;
            endcase
        end
        dim_d = dim(year_d, mon_d);
        if (day_d > dim_d) day_d = dim_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            field_q    <= 3'd0;
            time_set_q <= 1'b0;
            editing_q  <= 1'b0;
            year_q     <= 12'd2000;
            mon_q      <= 4'd1;
            day_q      <= 5'd1;
            week_q     <= 3'd1;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    time_set_q <= 1'b0;
                    if (bus.key_mode) begin
                        state_q   <= LOAD;
                        editing_q <= 1'b1;
                    end
                end
                LOAD: begin
                    year_q  <= ld_year;
                    mon_q   <= ld_mon;
                    day_q   <= ld_day;
                    week_q  <= ld_week;
                    hour_q  <= ld_hour;
                    min_q   <= ld_min;
                    sec_q   <= ld_sec;
                    field_q <= 3'd0;
                    state_q <= EDIT;
                end
                EDIT: begin
                    if (bus.key_mode) begin
                        state_q    <= COMMIT;
                        time_set_q <= 1'b1;
                        editing_q  <= 1'b0;
                    end else begin
                        year_q  <= year_d;
                        mon_q   <= mon_d;
                        day_q   <= day_d;
                        week_q  <= week_d;
                        hour_q  <= hour_d;
                        min_q   <= min_d;
                        sec_q   <= sec_d;
                        field_q <= field_d;
                    end
                end
                COMMIT: begin
                    time_set_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.year_set = year_q;
    assign bus.mon_set  = mon_q;
    assign bus.week_set = week_q;
    assign bus.day_set  = day_q;
    assign bus.hour_set = hour_q;
    assign bus.min_set  = min_q;
    assign bus.sec_set  = sec_q;
    assign bus.time_set = time_set_q;
    assign bus.editing  = editing_q;
    assign bus.field    = field_q;

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: load, edit, wrap, clamp, key priority
// and reset-abort scenarios with hand-computed expectations.
module tb_time_setter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;
    int   base    = 0;

    always #5 clk = ~clk;

    time_setter_if bus ();

    time_setter #(
        .YEAR_MIN(1900),
        .YEAR_MAX(2199)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) if (bus.time_set === 1'b1) strobes++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge
    task automatic press(input bit m, input bit n, input bit u, input bit d);
        bus.key_mode = m;
        bus.key_next = n;
        bus.key_up   = u;
        bus.key_down = d;
        @(negedge clk);
        bus.key_mode = 1'b0;
        bus.key_next = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
    endtask

    task automatic set_cur(input int y, input int mo, input int w,
                           input int d, input int h, input int mi,
                           input int s);
        bus.cur_year = 12'(y);
        bus.cur_mon  = 4'(mo);
        bus.cur_week = 3'(w);
        bus.cur_day  = 5'(d);
        bus.cur_hour = 5'(h);
        bus.cur_min  = 6'(mi);
        bus.cur_sec  = 6'(s);
    endtask

    task automatic load(input int y, input int mo, input int w,
                        input int d, input int h, input int mi,
                        input int s);
        set_cur(y, mo, w, d, h, mi, s);
        press(1, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic commit();
        press(1, 0, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        bus.key_mode = 1'b0;
        bus.key_next = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        set_cur(2015, 3, 3, 31, 10, 20, 30);

        repeat (3) @(negedge clk);
        check("rst_year", bus.year_set, 2000);
        check("rst_mon", bus.mon_set, 1);
        check("rst_day", bus.day_set, 1);
        check("rst_week", bus.week_set, 1);
        check("rst_hms", {bus.hour_set, bus.min_set, bus.sec_set}, 0);
        check("rst_tset", bus.time_set, 0);
        check("rst_edit", bus.editing, 0);
        check("rst_field", bus.field, 0);

        rst_n = 1'b1;
        base  = strobes;
        repeat (100) @(negedge clk);
        check("idle_nostrobe", strobes - base, 0);
        check("idle_year", bus.year_set, 2000);

        base = strobes;
        press(1, 0, 0, 0);
        check("load_editing", bus.editing, 1);
        check("load_year_old", bus.year_set, 2000);
        @(negedge clk);
        check("ld_year", bus.year_set, 2015);
        check("ld_mon", bus.mon_set, 3);
        check("ld_day", bus.day_set, 31);
        check("ld_week", bus.week_set, 3);
        check("ld_hour", bus.hour_set, 10);
        check("ld_min", bus.min_set, 20);
        check("ld_sec", bus.sec_set, 30);
        check("ld_field", bus.field, 0);
        press(0, 1, 0, 0);
        check("next_field", bus.field, 1);
        press(0, 0, 0, 1);
        check("clamp_mon", bus.mon_set, 2);
        check("clamp_day", bus.day_set, 28);
        press(1, 0, 0, 0);
        check("commit_tset", bus.time_set, 1);
        check("commit_edit", bus.editing, 0);
        check("commit_year", bus.year_set, 2015);
        check("commit_mon", bus.mon_set, 2);
        check("commit_day", bus.day_set, 28);
        @(negedge clk);
        check("post_tset", bus.time_set, 0);
        repeat (5) @(negedge clk);
        check("one_strobe", strobes - base, 1);
        check("hold_mon", bus.mon_set, 2);
        check("hold_day", bus.day_set, 28);

        load(2000, 2, 1, 29, 0, 0, 0);
        check("leap_ld_day", bus.day_set, 29);
        press(0, 0, 1, 0);
        check("leap_year", bus.year_set, 2001);
        check("leap_day", bus.day_set, 28);
        commit();

        load(2096, 2, 1, 29, 0, 0, 0);
        repeat (4) press(0, 0, 1, 0);
        check("c2100_year", bus.year_set, 2100);
        check("c2100_day", bus.day_set, 28);
        commit();

        load(2199, 12, 7, 1, 0, 0, 59);
        press(0, 0, 1, 0);
        check("year_wrap_up", bus.year_set, 1900);
        press(0, 0, 0, 1);
        check("year_wrap_dn", bus.year_set, 2199);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        check("mon_wrap_up", bus.mon_set, 1);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        check("week_wrap_up", bus.week_set, 1);
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        check("hour_wrap_dn", bus.hour_set, 23);
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        check("min_wrap_dn", bus.min_set, 59);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        check("sec_wrap_up", bus.sec_set, 0);
        press(0, 1, 0, 0);
        check("field_wrap", bus.field, 0);
        commit();

        load(2015, 4, 1, 1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        check("day_wrap_dn", bus.day_set, 30);

        press(0, 1, 1, 0);
        check("nx_up_field", bus.field, 3);
        check("nx_up_day", bus.day_set, 30);
        check("nx_up_week", bus.week_set, 1);
        base = strobes;
        press(1, 0, 1, 0);
        check("md_up_tset", bus.time_set, 1);
        check("md_up_week", bus.week_set, 1);
        @(negedge clk);

        press(0, 1, 1, 0);
        press(0, 0, 0, 1);
        press(0, 0, 1, 0);
        check("idle_keys_edit", bus.editing, 0);
        check("idle_keys_field", bus.field, 3);
        check("idle_keys_week", bus.week_set, 1);
        check("idle_keys_day", bus.day_set, 30);
        check("idle_keys_strobe", strobes - base, 1);

        load(2015, 0, 1, 15, 25, 0, 0);
        check("bad_mon", bus.mon_set, 1);
        check("bad_hour", bus.hour_set, 0);
        check("bad_day_ok", bus.day_set, 15);
        press(0, 0, 1, 0);
        check("abort_pre", bus.year_set, 2016);
        base = strobes;
        #2 rst_n = 1'b0;
        #1;
        check("abort_year", bus.year_set, 2000);
        check("abort_day", bus.day_set, 1);
        check("abort_edit", bus.editing, 0);
        check("abort_field", bus.field, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_strobe", strobes - base, 0);
        check("abort_idle", bus.editing, 0);
        check("abort_hold", bus.year_set, 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
